// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-light controller and its input conditioner.
// Contents: light encodings, default timing constants, channel indices, edge helper.
package traffic_pkg;

    typedef enum logic [1:0] {
        GREEN  = 2'd0,
        YELLOW = 2'd1,
        RED    = 2'd2
    } light_t;

    localparam int unsigned SYNC_STAGES_DEF = 2;
    localparam int unsigned DEB_CYCLES_DEF  = 8;
    localparam int unsigned HOLD_CYCLES_DEF = 32;

    // Bit positions of the four street inputs inside the conditioner.
    localparam int unsigned CH_A = 0;
    localparam int unsigned CH_B = 1;
    localparam int unsigned CH_P = 2;
    localparam int unsigned CH_R = 3;

    function automatic logic rise_edge(input logic cur, input logic prev);
        return cur & ~prev;
    endfunction

endpackage

// File: rtl/tsc_debounce.sv
// One input channel: SYNC_STAGES-flop synchroniser followed by a debouncer.
// Ports: i_clk, i_rstn (async active-low), i_raw (async input), o_deb (level).
module tsc_debounce
    import traffic_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int unsigned DEB_CYCLES  = DEB_CYCLES_DEF
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_raw,
    output logic o_deb
);

    localparam int unsigned CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   sync;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   deb_q, deb_d;

    assign sync = sync_q[SYNC_STAGES-1];

    // The level flips on the DEB_CYCLES-th consecutive disagreeing
    // sample; any agreeing sample (or the flip itself) clears the count.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], i_raw};
        cnt_d  = '0;
        deb_d  = deb_q;
        if (sync != deb_q) begin
            if (cnt_q == CNT_LAST) begin
                deb_d = sync;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            sync_q <= '0;
            cnt_q  <= '0;
            deb_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            deb_q  <= deb_d;
        end
    end

    assign o_deb = deb_q;

endmodule

// File: rtl/traffic_sensor_cond.sv
// Input conditioner feeding the traffic-light controller FSM.
// Inputs: i_clk, i_rstn (async active-low), two raw car loops, two raw buttons.
// Outputs: o_TA/o_TB registered traffic levels, o_P/o_R registered 1-cycle pulses.
// Macro TSC_GAP_HOLD_EN: when defined, o_TA/o_TB bridge gaps of HOLD_CYCLES.
module traffic_sensor_cond
    import traffic_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int unsigned DEB_CYCLES  = DEB_CYCLES_DEF,
    parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEF
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_sensor_a_raw,
    input  logic i_sensor_b_raw,
    input  logic i_parade_btn,
    input  logic i_release_btn,
    output logic o_TA,
    output logic o_TB,
    output logic o_P,
    output logic o_R
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be >= 2");
    end
    if (DEB_CYCLES < 1) begin : g_bad_deb
        $error("DEB_CYCLES must be >= 1");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $error("HOLD_CYCLES must be >= 1");
    end

    logic [3:0] raw;
    logic [3:0] deb;

    assign raw = {i_release_btn, i_parade_btn,
                  i_sensor_b_raw, i_sensor_a_raw};

    for (genvar g = 0; g < 4; g++) begin : g_ch
        tsc_debounce #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEB_CYCLES  (DEB_CYCLES)
        ) u_deb (
            .i_clk  (i_clk),
            .i_rstn (i_rstn),
            .i_raw  (raw[g]),
            .o_deb  (deb[g])
        );
    end

    logic [1:0] btn_prev_q, btn_prev_d;
    logic       rise_p, rise_r;
    logic       p_q, p_d, r_q, r_d;
    logic       ta_q, ta_d, tb_q, tb_d;

    // Release outranks start when both debounce on the same cycle.
    always_comb begin
        btn_prev_d = {deb[CH_R], deb[CH_P]};
        rise_p     = rise_edge(deb[CH_P], btn_prev_q[0]);
        rise_r     = rise_edge(deb[CH_R], btn_prev_q[1]);
        p_d        = rise_p & ~rise_r;
        r_d        = rise_r;
    end

`ifdef TSC_GAP_HOLD_EN
    localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES);

    logic [HW-1:0] hold_a_q, hold_a_d;
    logic [HW-1:0] hold_b_q, hold_b_d;

    // Hold reloads while traffic is seen and drains once it goes away,
    // so a short gap between cars never drops the level.
    always_comb begin
        hold_a_d = deb[CH_A] ? HOLD_LOAD :
                   (hold_a_q != '0) ? hold_a_q - 1'b1 : '0;
        hold_b_d = deb[CH_B] ? HOLD_LOAD :
                   (hold_b_q != '0) ? hold_b_q - 1'b1 : '0;
        ta_d     = deb[CH_A] | (hold_a_q != '0);
        tb_d     = deb[CH_B] | (hold_b_q != '0);
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            hold_a_q <= '0;
            hold_b_q <= '0;
        end else begin
            hold_a_q <= hold_a_d;
            hold_b_q <= hold_b_d;
        end
    end
`else
    always_comb begin
        ta_d = deb[CH_A];
        tb_d = deb[CH_B];
    end
`endif

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            btn_prev_q <= '0;
            p_q        <= 1'b0;
            r_q        <= 1'b0;
            ta_q       <= 1'b0;
            tb_q       <= 1'b0;
        end else begin
            btn_prev_q <= btn_prev_d;
            p_q        <= p_d;
            r_q        <= r_d;
            ta_q       <= ta_d;
            tb_q       <= tb_d;
        end
    end

    assign o_TA = ta_q;
    assign o_TB = tb_q;
    assign o_P  = p_q;
    assign o_R  = r_q;

endmodule

// File: tb/tb_traffic_sensor_cond.sv
// Self-checking bench for traffic_sensor_cond with a windowed reference model.
// Works with and without TSC_GAP_HOLD_EN defined.
module tb_traffic_sensor_cond;

    localparam int SYNC = 2;
    localparam int DEB  = 8;
    localparam int HOLD = 32;
    localparam int MAXC = 8192;

`ifdef TSC_GAP_HOLD_EN
    localparam int FALL_LAT = SYNC + DEB + 1 + HOLD;
`else
    localparam int FALL_LAT = SYNC + DEB + 1;
`endif
    localparam int RISE_LAT = SYNC + DEB + 1;

    logic clk, rst_n;
    logic sa, sb, pb, rb;
    logic o_ta, o_tb, o_p, o_r;

    traffic_sensor_cond dut (
        .i_clk          (clk),
        .i_rstn         (rst_n),
        .i_sensor_a_raw (sa),
        .i_sensor_b_raw (sb),
        .i_parade_btn   (pb),
        .i_release_btn  (rb),
        .o_TA           (o_ta),
        .o_TB           (o_tb),
        .o_P            (o_p),
        .o_R            (o_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: per channel, raw value seen at each edge since reset and the
    // debounced level after each edge.
    bit raw_h [4][MAXC];
    bit deb_h [4][MAXC];
    int last_t [4];
    int k;
    logic [3:0] exp_vec;
    logic [3:0] obs;
    int checks = 0;
    int errors = 0;

    assign obs = {o_ta, o_tb, o_p, o_r};

    task automatic model_reset();
        k = 0;
        for (int ch = 0; ch < 4; ch++) begin
            last_t[ch]   = 0;
            deb_h[ch][0] = 1'b0;
        end
        exp_vec = 4'b0000;
    endtask

    // Debounced level flips at edge k when the DEB samples ending at k,
    // all taken after the previous flip, all disagree with the level.
    // Sample at edge j is the raw value seen SYNC edges earlier.
    task automatic step();
        logic [3:0] rv;
        bit tog, s, ta, tb, rp, rr;
        int lo;
        @(posedge clk);
        k++;
        rv = {rb, pb, sb, sa};
        for (int ch = 0; ch < 4; ch++) begin
            raw_h[ch][k] = rv[ch];
            tog = (k - DEB >= last_t[ch]);
            for (int j = k - DEB + 1; j <= k; j++) begin
                s = (j - SYNC >= 1) ? raw_h[ch][j-SYNC] : 1'b0;
                if (j < 1 || s == deb_h[ch][k-1]) tog = 1'b0;
            end
            deb_h[ch][k] = tog ? ~deb_h[ch][k-1] : deb_h[ch][k-1];
            if (tog) last_t[ch] = k;
        end
`ifdef TSC_GAP_HOLD_EN
        lo = k - 1 - HOLD;
        if (lo < 0) lo = 0;
        ta = 1'b0;
        tb = 1'b0;
        for (int j = lo; j <= k - 1; j++) begin
            ta = ta | deb_h[0][j];
            tb = tb | deb_h[1][j];
        end
`else
        lo = 0;
        ta = deb_h[0][k-1];
        tb = deb_h[1][k-1];
`endif
        rp = deb_h[2][k-1] & ~((k >= 2) ? deb_h[2][k-2] : 1'b0);
        rr = deb_h[3][k-1] & ~((k >= 2) ? deb_h[3][k-2] : 1'b0);
        exp_vec = {ta, tb, rp & ~rr, rr};
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        {sa, sb, pb, rb} = 4'b0000;
        model_reset();
        #3;
        checks++;
        if (obs !== 4'b0000) begin
            errors++;
            $display("FAIL reset_state obs=%b exp=0000", obs);
        end
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int n = 0; n < 20; n++) begin
            step();
            checks++;
            if (obs !== exp_vec || obs !== 4'b0000) begin
                errors++;
                $display("FAIL reset_idle k=%0d obs=%b exp=%b",
                         k, obs, exp_vec);
            end
        end
    endtask

    task automatic test_glitch();
        int ta_seen = 0;
        sa = 1'b1;
        for (int n = 0; n < 5; n++) begin
            step();
            checks++;
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL glitch_pulse k=%0d obs=%b exp=%b",
                         k, obs, exp_vec);
            end
            ta_seen += int'(o_ta);
        end
        sa = 1'b0;
        for (int n = 0; n < 30; n++) begin
            if (n < 10) sa = ~sa;
            else sa = 1'b0;
            step();
            checks++;
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL glitch_toggle k=%0d obs=%b exp=%b",
                         k, obs, exp_vec);
            end
            ta_seen += int'(o_ta);
        end
        checks++;
        if (ta_seen !== 0) begin
            errors++;
            $display("FAIL glitch_ta_high cycles=%0d exp=0", ta_seen);
        end
    endtask

    task automatic test_rise();
        int rise_n = 0;
        int tb_seen = 0;
        sa = 1'b1;
        for (int n = 1; n <= 30; n++) begin
            step();
            checks++;
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL rise_model k=%0d obs=%b exp=%b",
                         k, obs, exp_vec);
            end
            if (o_ta === 1'b1 && rise_n == 0) rise_n = n;
            tb_seen += int'(o_tb);
        end
        checks++;
        if (rise_n !== RISE_LAT || o_ta !== 1'b1) begin
            errors++;
            $display("FAIL rise_latency got=%0d exp=%0d ta=%b",
                     rise_n, RISE_LAT, o_ta);
        end
        checks++;
        if (tb_seen !== 0) begin
            errors++;
            $display("FAIL rise_tb_isolation cycles=%0d exp=0", tb_seen);
        end
    endtask

    task automatic test_fall(input int ch);
        int fall_n = 0;
        if (ch == 0) sa = 1'b1;
        else sb = 1'b1;
        for (int n = 0; n < 30; n++) begin
            step();
            checks++;
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL fall_setup%0d k=%0d obs=%b exp=%b",
                         ch, k, obs, exp_vec);
            end
        end
        if (ch == 0) sa = 1'b0;
        else sb = 1'b0;
        for (int n = 1; n <= FALL_LAT + 10; n++) begin
            step();
            checks++;
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL fall_model%0d k=%0d obs=%b exp=%b",
                         ch, k, obs, exp_vec);
            end
            if (fall_n == 0 && obs[3-ch] === 1'b0) fall_n = n;
        end
        checks++;
        if (fall_n !== FALL_LAT) begin
            errors++;
            $display("FAIL fall_latency%0d got=%0d exp=%0d",
                     ch, fall_n, FALL_LAT);
        end
    endtask

`ifdef TSC_GAP_HOLD_EN
    task automatic test_gap_hold();
        int drops = 0;
        sa = 1'b1;
        for (int n = 1; n <= 80; n++) begin
            if (n == 21) sa = 1'b0;
            if (n == 41) sa = 1'b1;
            step();
            checks++;
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL gap_model k=%0d obs=%b exp=%b",
                         k, obs, exp_vec);
            end
            if (n > RISE_LAT && o_ta !== 1'b1) drops++;
        end
        checks++;
        if (drops !== 0) begin
            errors++;
            $display("FAIL gap_hold drops=%0d exp=0", drops);
        end
        sa = 1'b0;
        for (int n = 0; n < FALL_LAT + 5; n++) step();
    endtask
`endif

    task automatic test_button();
        int p_hi = 0;
        int r_hi = 0;
        for (int n = 0; n < 130; n++) begin
            pb = (n < 100) && (n != 1);
            step();
            checks++;
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL btn_model k=%0d obs=%b exp=%b",
                         k, obs, exp_vec);
            end
            p_hi += int'(o_p);
            r_hi += int'(o_r);
        end
        checks++;
        if (p_hi !== 1 || r_hi !== 0) begin
            errors++;
            $display("FAIL btn_single_pulse p=%0d r=%0d exp p=1 r=0",
                     p_hi, r_hi);
        end
        p_hi = 0;
        r_hi = 0;
        for (int n = 0; n < 60; n++) begin
            pb = (n < 30);
            rb = (n < 30);
            step();
            checks++;
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL both_model k=%0d obs=%b exp=%b",
                         k, obs, exp_vec);
            end
            p_hi += int'(o_p);
            r_hi += int'(o_r);
        end
        checks++;
        if (p_hi !== 0 || r_hi !== 1) begin
            errors++;
            $display("FAIL both_priority p=%0d r=%0d exp p=0 r=1",
                     p_hi, r_hi);
        end
    endtask

    task automatic test_mid_reset();
        int late = 0;
        sa = 1'b1;
        for (int n = 0; n < 20; n++) step();
        sa = 1'b0;
        for (int n = 0; n < 5; n++) step();
        checks++;
        if (obs !== exp_vec || o_ta !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre obs=%b exp=%b", obs, exp_vec);
        end
        {sa, sb, pb, rb} = 4'b0000;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 4'b0000) begin
            errors++;
            $display("FAIL midrst_async obs=%b exp=0000", obs);
        end
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int n = 0; n < 50; n++) begin
            step();
            if (obs !== 4'b0000) late++;
        end
        checks++;
        if (late !== 0) begin
            errors++;
            $display("FAIL midrst_after nonzero_cycles=%0d exp=0", late);
        end
    endtask

    task automatic test_random();
        int rst_at;
        rst_at = $urandom_range(800, 1600);
        for (int n = 0; n < 2500; n++) begin
            if ($urandom_range(0, 9) == 0) sa = ~sa;
            if ($urandom_range(0, 9) == 0) sb = ~sb;
            if ($urandom_range(0, 11) == 0) pb = ~pb;
            if ($urandom_range(0, 11) == 0) rb = ~rb;
            if (n == rst_at) begin
                #2 rst_n = 1'b0;
                #1;
                checks++;
                if (obs !== 4'b0000) begin
                    errors++;
                    $display("FAIL rand_async_rst obs=%b exp=0000", obs);
                end
                model_reset();
                @(posedge clk);
                #1 rst_n = 1'b1;
            end
            step();
            checks++;
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL random k=%0d raw=%b obs=%b exp=%b",
                         k, {rb, pb, sb, sa}, obs, exp_vec);
            end
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_rise();
        test_fall(0);
        test_fall(1);
`ifdef TSC_GAP_HOLD_EN
        test_gap_hold();
`endif
        test_button();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout k=%0d", k);
        $fatal(1, "timeout");
    end

endmodule
